// File: rtl/spi_poll_seq_pkg.sv
// Shared state encoding and SPI IP register map for the polling sequencer.
package gyro_parameters;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_WR_TX,
    ST_WR_GO,
    ST_RD_STAT,
    ST_RD_RX,
    ST_FAULT
  } state_t;

  localparam int unsigned SPI_TXDATA    = 'h0;
  localparam int unsigned SPI_CTRL      = 'h4;
  localparam int unsigned SPI_STATUS    = 'h8;
  localparam int unsigned SPI_RXDATA    = 'hC;
  localparam int unsigned STAT_DONE_BIT = 0;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/spi_poll_seq_axil.sv
// Single-transaction AXI-lite master: one read or write per request, at most one outstanding.
module axil_single_master #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_req,
  input  logic          i_write,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic          o_done,
  output logic [1:0]    o_resp,
  output logic [DW-1:0] o_rdata,
  output logic [AW-1:0] m_axil_awaddr,
  output logic [2:0]    m_axil_awprot,
  output logic          m_axil_awvalid,
  input  logic          m_axil_awready,
  output logic [DW-1:0] m_axil_wdata,
  output logic [DW/8-1:0] m_axil_wstrb,
  output logic          m_axil_wvalid,
  input  logic          m_axil_wready,
  input  logic [1:0]    m_axil_bresp,
  input  logic          m_axil_bvalid,
  output logic          m_axil_bready,
  output logic [AW-1:0] m_axil_araddr,
  output logic [2:0]    m_axil_arprot,
  output logic          m_axil_arvalid,
  input  logic          m_axil_arready,
  input  logic [DW-1:0] m_axil_rdata,
  input  logic [1:0]    m_axil_rresp,
  input  logic          m_axil_rvalid,
  output logic          m_axil_rready
);

  logic          r_busy;
  logic          r_wr;
  logic          r_awvalid;
  logic          r_wvalid;
  logic          r_arvalid;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          w_bdone;
  logic          w_rdone;

  assign w_bdone = r_busy && r_wr && m_axil_bvalid;
  assign w_rdone = r_busy && !r_wr && m_axil_rvalid;

  // A new request is only accepted once the previous response has been taken.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_busy    <= 1'b0;
      r_wr      <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_arvalid <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else if (!r_busy) begin
      if (i_req) begin
        r_busy    <= 1'b1;
        r_wr      <= i_write;
        r_addr    <= i_addr;
        r_wdata   <= i_wdata;
        r_awvalid <= i_write;
        r_wvalid  <= i_write;
        r_arvalid <= !i_write;
      end
    end else begin
      if (m_axil_awready) r_awvalid <= 1'b0;
      if (m_axil_wready)  r_wvalid  <= 1'b0;
      if (m_axil_arready) r_arvalid <= 1'b0;
      if (w_bdone || w_rdone) r_busy <= 1'b0;
    end
  end

  assign o_done         = w_bdone || w_rdone;
  assign o_resp         = r_wr ? m_axil_bresp : m_axil_rresp;
  assign o_rdata        = m_axil_rdata;

  assign m_axil_awaddr  = r_addr;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_awvalid = r_awvalid;
  assign m_axil_wdata   = r_wdata;
  assign m_axil_wstrb   = '1;
  assign m_axil_wvalid  = r_wvalid;
  assign m_axil_bready  = r_busy && r_wr;
  assign m_axil_araddr  = r_addr;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_arvalid = r_arvalid;
  assign m_axil_rready  = r_busy && !r_wr;

endmodule

// File: rtl/spi_poll_seq.sv
// Periodic SPI sampler: writes TX, kicks the transfer, polls STATUS, then reads RX.
module spi_poll_seq
  import gyro_parameters::*;
#(
  parameter int unsigned AW       = 4,
  parameter int unsigned DW       = 32,
  parameter int unsigned PERIOD_W = 24,
  parameter int unsigned TMO_CYC  = 1024
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  input  logic [DW-1:0]       cmd,
  output logic [AW-1:0]       m_axil_awaddr,
  output logic [2:0]          m_axil_awprot,
  output logic                m_axil_awvalid,
  input  logic                m_axil_awready,
  output logic [DW-1:0]       m_axil_wdata,
  output logic [DW/8-1:0]     m_axil_wstrb,
  output logic                m_axil_wvalid,
  input  logic                m_axil_wready,
  input  logic [1:0]          m_axil_bresp,
  input  logic                m_axil_bvalid,
  output logic                m_axil_bready,
  output logic [AW-1:0]       m_axil_araddr,
  output logic [2:0]          m_axil_arprot,
  output logic                m_axil_arvalid,
  input  logic                m_axil_arready,
  input  logic [DW-1:0]       m_axil_rdata,
  input  logic [1:0]          m_axil_rresp,
  input  logic                m_axil_rvalid,
  output logic                m_axil_rready,
  output logic [DW-1:0]       sample,
  output logic                sample_vld,
  output logic                busy,
  output logic                err
);

  localparam int unsigned POLL_W = $clog2(TMO_CYC + 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PERIOD_W-1:0] r_cnt;
  logic [POLL_W-1:0]   r_polls;
  logic [DW-1:0]       r_cmd;
  logic [DW-1:0]       r_sample;
  logic                r_sample_vld;
  logic                r_err;

  logic                w_req;
  logic                w_write;
  logic [AW-1:0]       w_addr;
  logic [DW-1:0]       w_wdata;
  logic                w_done;
  logic [1:0]          w_resp;
  logic [DW-1:0]       w_rdata;
  logic                w_resp_ok;
  logic                w_poll_miss;
  logic                w_start_sample;
  logic                w_load_cnt;

  assign w_resp_ok = (w_resp == RESP_OKAY);

  axil_single_master #(
    .AW (AW),
    .DW (DW)
  ) u_axil (
    .clk            (clk),
    .rstn           (rstn),
    .i_req          (w_req),
    .i_write        (w_write),
    .i_addr         (w_addr),
    .i_wdata        (w_wdata),
    .o_done         (w_done),
    .o_resp         (w_resp),
    .o_rdata        (w_rdata),
    .m_axil_awaddr  (m_axil_awaddr),
    .m_axil_awprot  (m_axil_awprot),
    .m_axil_awvalid (m_axil_awvalid),
    .m_axil_awready (m_axil_awready),
    .m_axil_wdata   (m_axil_wdata),
    .m_axil_wstrb   (m_axil_wstrb),
    .m_axil_wvalid  (m_axil_wvalid),
    .m_axil_wready  (m_axil_wready),
    .m_axil_bresp   (m_axil_bresp),
    .m_axil_bvalid  (m_axil_bvalid),
    .m_axil_bready  (m_axil_bready),
    .m_axil_araddr  (m_axil_araddr),
    .m_axil_arprot  (m_axil_arprot),
    .m_axil_arvalid (m_axil_arvalid),
    .m_axil_arready (m_axil_arready),
    .m_axil_rdata   (m_axil_rdata),
    .m_axil_rresp   (m_axil_rresp),
    .m_axil_rvalid  (m_axil_rvalid),
    .m_axil_rready  (m_axil_rready)
  );

  // The master issues a transaction whenever a bus state is active and it is idle,
  // so staying in RD_STAT after a miss automatically reissues the poll.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_write     = 1'b0;
    w_addr      = '0;
    w_wdata     = '0;
    w_poll_miss = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (en) w_state_nxt = ST_WR_TX;
      end
      ST_WAIT: begin
        if (r_cnt <= PERIOD_W'(1)) w_state_nxt = en ? ST_WR_TX : ST_IDLE;
      end
      ST_WR_TX: begin
        w_req   = 1'b1;
        w_write = 1'b1;
        w_addr  = AW'(SPI_TXDATA);
        w_wdata = r_cmd;
        if (w_done) w_state_nxt = w_resp_ok ? ST_WR_GO : ST_FAULT;
      end
      ST_WR_GO: begin
        w_req   = 1'b1;
        w_write = 1'b1;
        w_addr  = AW'(SPI_CTRL);
        w_wdata = DW'(1);
        if (w_done) w_state_nxt = w_resp_ok ? ST_RD_STAT : ST_FAULT;
      end
      ST_RD_STAT: begin
        w_req  = 1'b1;
        w_addr = AW'(SPI_STATUS);
        if (w_done) begin
          if (!w_resp_ok) begin
            w_state_nxt = ST_FAULT;
          end else if (w_rdata[STAT_DONE_BIT]) begin
            w_state_nxt = ST_RD_RX;
          end else begin
            w_poll_miss = 1'b1;
            if (r_polls == POLL_W'(TMO_CYC - 1)) w_state_nxt = ST_FAULT;
          end
        end
      end
      ST_RD_RX: begin
        w_req  = 1'b1;
        w_addr = AW'(SPI_RXDATA);
        if (w_done) begin
          if (!w_resp_ok) w_state_nxt = ST_FAULT;
          else            w_state_nxt = en ? ST_WAIT : ST_IDLE;
        end
      end
      ST_FAULT: begin
        if (!en) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_start_sample = (w_state_nxt == ST_WR_TX) &&
                          ((r_state == ST_IDLE) || (r_state == ST_WAIT));
  assign w_load_cnt     = ((r_state == ST_IDLE) && en) ||
                          ((r_state == ST_RD_RX) && (w_state_nxt == ST_WAIT));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_polls      <= '0;
      r_cmd        <= '0;
      r_sample     <= '0;
      r_sample_vld <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sample_vld <= 1'b0;
      if (w_start_sample) r_cmd <= cmd;
      if (w_load_cnt) begin
        r_cnt <= period;
      end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (r_state == ST_WR_GO) begin
        r_polls <= '0;
      end else if (w_poll_miss) begin
        r_polls <= r_polls + 1'b1;
      end
      if ((r_state == ST_RD_RX) && w_done && w_resp_ok) begin
        r_sample     <= w_rdata;
        r_sample_vld <= 1'b1;
      end
      // A fault arriving while en is low must still be flagged.
      if ((w_state_nxt == ST_FAULT) && (r_state != ST_FAULT)) begin
        r_err <= 1'b1;
      end else if (!en) begin
        r_err <= 1'b0;
      end
    end
  end

  assign sample     = r_sample;
  assign sample_vld = r_sample_vld;
  assign busy       = (r_state != ST_IDLE) && (r_state != ST_WAIT);
  assign err        = r_err;

endmodule

// File: doc/spi_poll_seq.md
SPI_POLL_SEQ -- requirements
Module: spi_poll_seq

Interface
REQ-001 Parameter AW, 4, AXI-lite address width toward the SPI IP.
REQ-002 Parameter DW, 32, AXI-lite data width.
REQ-003 Parameter PERIOD_W, 24, width of the sample-period counter.
REQ-004 Parameter TMO_CYC, 1024, maximum status polls per transfer before timeout.
REQ-005 One clock, clk; reset rstn is synchronous and active-low.
REQ-006 clk  in  1  system clock.
REQ-007 rstn  in  1  synchronous active-low reset.
REQ-008 en  in  1  level; enables periodic sampling.
REQ-009 period  in  PERIOD_W  cycles between sample starts; 0 means back-to-back.
REQ-010 cmd  in  DW  word written to SPI TX register each sample; captured at sample start.
REQ-011 m_axil  master  AXI-lite (aw/w/b/ar/r, AW/DW, prot=0, wstrb all ones)  connects to the SPI IP consumer port.
REQ-012 sample  out  DW  last RX word read.
REQ-013 sample_vld  out  1  one-cycle pulse when sample updates.
REQ-014 busy  out  1  high while any state other than IDLE or WAIT is active.
REQ-015 err  out  1  sticky error flag; cleared only by en low for one cycle.

Function
REQ-016 SPI IP map: 0x0 TXDATA, 0x4 CTRL (write 1 = go), 0x8 STATUS (bit0 = done), 0xC RXDATA.
REQ-017 States: IDLE, WAIT, WR_TX, WR_GO, RD_STAT, RD_RX, FAULT.
REQ-018 IDLE -> WR_TX when en=1; period counter loads period.
REQ-019 Write states: awvalid and wvalid asserted together; each drops on its own ready; bready=1; advance on bvalid.
REQ-020 Read states: arvalid until arready; rready=1; evaluate on rvalid.
REQ-021 WR_TX -> WR_GO -> RD_STAT on OKAY bresp.
REQ-022 RD_STAT: done=1 -> RD_RX; done=0 -> reissue read, increment poll count.
REQ-023 Poll count reaching TMO_CYC -> FAULT; err set.
REQ-024 RD_RX: capture rdata into sample, pulse sample_vld with rvalid handshake+1 cycle, -> WAIT.
REQ-025 Any bresp/rresp non-zero -> FAULT, err set, sample unchanged.
REQ-026 WAIT: counter decrements each cycle; at 0 -> WR_TX if en=1, else IDLE.
REQ-027 en deassert mid-transfer: current transfer completes to RD_RX; then IDLE.
REQ-028 FAULT: all valids low; -> IDLE when en=0.
REQ-029 Never more than one outstanding AXI transaction; valid never withdrawn before ready.
REQ-030 Period counter does not wrap; period change takes effect at next WAIT entry.

Reset
REQ-031 On rstn=0 at clk edge: state IDLE, all valids 0, bready/rready 0, sample 0, sample_vld 0, busy 0, err 0, counters 0.
REQ-032 Reset mid-transaction abandons it without completing handshakes.

Structure
REQ-033 State enum, SPI register offsets and STATUS bit index in gyro_parameters package.
REQ-034 One sub-module, axil_single_master, performs one read or write transaction and returns resp/data.

Verification
REQ-035 en=1, period=100, cmd=0x8F00, slave returns done after 3 polls, RX=0x1234 -> sample=0x1234, one sample_vld, next WR_TX 100 cycles after WAIT entry.
REQ-036 awready delayed 5 cycles, wready immediate -> wvalid drops first, awvalid held stable, single bvalid accepted.
REQ-037 STATUS never done -> FAULT after 1024 polls, err=1, no sample_vld; en low clears err.
REQ-038 rresp=SLVERR on RXDATA -> FAULT, sample keeps previous value.
REQ-039 en dropped during RD_STAT -> transfer finishes, sample_vld pulses, state IDLE.
REQ-040 rstn low while arvalid=1 -> next cycle arvalid=0, all outputs at reset values.
